dsa_xocc_chan_ctrl: RTL and testbench

- DSA-side channel controller for one XOCC queue, directly downstream of the XOCC command FIFO and upstream of the XOCC response FIFO.
- Pops one 96-bit command from the FWFT command FIFO and issues it to the accelerator over a valid/ready request channel.
- Waits for the tagged result, with a timeout, then pushes one 32-bit response word into the response FIFO.
- One instance per populated queue, clocked by that queue's dsa_clk bit.

---
 rtl/dsa_chan_pkg.sv | 20 ++
 rtl/dsa_sat_cnt.sv | 23 ++
 rtl/dsa_xocc_chan_ctrl.sv | 143 ++++++++++++++
 tb/tb_dsa_xocc_chan_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsa_chan_pkg.sv
// rtl/dsa_chan_pkg.sv - shared types and field layout for the DSA channel controller
package dsa_chan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RSP
  } chan_state_e;

  localparam logic [7:0]  OPC_NOP  = 8'h00;
  localparam logic [15:0] TMO_MARK = 16'hDEAD;

  localparam int OPC_LSB = 0;
  localparam int TAG_LSB = 8;
  localparam int W0_LSB  = 0;
  localparam int W1_LSB  = 32;
  localparam int W2_LSB  = 64;

endpackage

// File: rtl/dsa_sat_cnt.sv
// rtl/dsa_sat_cnt.sv - saturating event counter with synchronous clear
module dsa_sat_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dsa_xocc_chan_ctrl.sv
// rtl/dsa_xocc_chan_ctrl.sv - pops one XOCC command, issues it to the accelerator, pushes one response
module dsa_xocc_chan_ctrl
  import dsa_chan_pkg::*;
#(
  parameter int CMD_WIDTH = 96,
  parameter int RSP_WIDTH = 32,
  parameter int TAG_WIDTH = 8,
  parameter int TMO_CYC   = 1024
) (
  input  logic                 dsa_clk,
  input  logic                 dsa_rst,
  input  logic [CMD_WIDTH-1:0] dsa_cmd_buffer,
  input  logic                 empty_cmd,
  output logic                 rd_en_cmd,
  output logic [RSP_WIDTH-1:0] dsa_rsp_buffer,
  output logic                 wr_en_rsp,
  input  logic                 full_rsp,
  output logic                 acc_req_vld,
  input  logic                 acc_req_rdy,
  output logic [7:0]           acc_req_opc,
  output logic [TAG_WIDTH-1:0] acc_req_tag,
  output logic [31:0]          acc_req_arg0,
  output logic [31:0]          acc_req_arg1,
  input  logic                 acc_rsp_vld,
  output logic                 acc_rsp_rdy,
  input  logic [TAG_WIDTH-1:0] acc_rsp_tag,
  input  logic [31:0]          acc_rsp_data,
  output logic                 busy,
  output logic [15:0]          stat_cmd_cnt,
  output logic [7:0]           stat_tmo_cnt,
  output logic [7:0]           stat_drop_cnt
);

  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

  chan_state_e          r_state, w_state_nxt;
  logic [7:0]           r_opc;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [31:0]          r_arg0, r_arg1;
  logic [RSP_WIDTH-1:0] r_rsp;
  logic [TW-1:0]        r_tmo;
  logic [15:0]          r_cmd_cnt;

  logic [7:0]           w_in_opc;
  logic [TAG_WIDTH-1:0] w_in_tag;
  logic                 w_match, w_tmo_hit, w_expire, w_drop;
  logic                 w_unused_hdr;

  assign w_in_opc     = dsa_cmd_buffer[W0_LSB+OPC_LSB +: 8];
  assign w_in_tag     = dsa_cmd_buffer[W0_LSB+TAG_LSB +: TAG_WIDTH];
  assign w_unused_hdr = ^dsa_cmd_buffer[31:TAG_LSB+TAG_WIDTH];
  assign w_expire     = (TMO_CYC != 0) && (r_tmo == TMO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    rd_en_cmd   = 1'b0;
    acc_req_vld = 1'b0;
    wr_en_rsp   = 1'b0;
    w_match     = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!empty_cmd) begin
          rd_en_cmd   = 1'b1;
          w_state_nxt = (w_in_opc == OPC_NOP) ? ST_RSP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        acc_req_vld = 1'b1;
        if (acc_req_rdy) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A matching result beats a coincident expiry.
        if (acc_rsp_vld && (acc_rsp_tag == r_tag)) begin
          w_match     = 1'b1;
          w_state_nxt = ST_RSP;
        end else if (w_expire) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        wr_en_rsp = !full_rsp;
        if (!full_rsp) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign acc_rsp_rdy = (r_state != ST_RSP);
  assign w_drop      = acc_rsp_vld && acc_rsp_rdy && !w_match;

  always_ff @(posedge dsa_clk) begin
    if (dsa_rst) begin
      r_state   <= ST_IDLE;
      r_opc     <= '0;
      r_tag     <= '0;
      r_arg0    <= '0;
      r_arg1    <= '0;
      r_rsp     <= '0;
      r_tmo     <= '0;
      r_cmd_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (rd_en_cmd) begin
        r_opc     <= w_in_opc;
        r_tag     <= w_in_tag;
        r_arg0    <= dsa_cmd_buffer[W1_LSB +: 32];
        r_arg1    <= dsa_cmd_buffer[W2_LSB +: 32];
        r_cmd_cnt <= r_cmd_cnt + 16'd1;
        if (w_in_opc == OPC_NOP) r_rsp <= RSP_WIDTH'(w_in_tag);
      end
      if (r_state == ST_ISSUE) r_tmo <= '0;
      else if (r_state == ST_WAIT) r_tmo <= r_tmo + TW'(1);
      if (w_match) r_rsp <= RSP_WIDTH'(acc_rsp_data);
      else if (w_tmo_hit) r_rsp <= RSP_WIDTH'({TMO_MARK, 8'h00, r_tag});
    end
  end

  dsa_sat_cnt #(.W(8)) u_tmo_cnt (
    .i_clk (dsa_clk),
    .i_clr (dsa_rst),
    .i_inc (w_tmo_hit),
    .o_cnt (stat_tmo_cnt)
  );

  dsa_sat_cnt #(.W(8)) u_drop_cnt (
    .i_clk (dsa_clk),
    .i_clr (dsa_rst),
    .i_inc (w_drop),
    .o_cnt (stat_drop_cnt)
  );

  assign acc_req_opc    = r_opc;
  assign acc_req_tag    = r_tag;
  assign acc_req_arg0   = r_arg0;
  assign acc_req_arg1   = r_arg1;
  assign dsa_rsp_buffer = r_rsp;
  assign busy           = (r_state != ST_IDLE);
  assign stat_cmd_cnt   = r_cmd_cnt;

endmodule

// File: tb/tb_dsa_xocc_chan_ctrl.sv
// tb/tb_dsa_xocc_chan_ctrl.sv - directed self-checking bench for dsa_xocc_chan_ctrl
module tb_dsa_xocc_chan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] cmd;
  logic        empty_cmd;
  logic        rd_en_cmd;
  logic [31:0] rsp_buf;
  logic        wr_en_rsp;
  logic        full_rsp;
  logic        req_vld, req_rdy;
  logic [7:0]  req_opc, req_tag;
  logic [31:0] req_arg0, req_arg1;
  logic        rsp_vld, rsp_rdy;
  logic [7:0]  rsp_tag;
  logic [31:0] rsp_data;
  logic        busy;
  logic [15:0] cmd_cnt;
  logic [7:0]  tmo_cnt, drop_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_vld = 0;
  int cyc = 0;
  logic [31:0] push_data[$];
  int          push_cyc[$];

  always #5 clk = ~clk;

  dsa_xocc_chan_ctrl #(.TMO_CYC(16)) dut (
    .dsa_clk        (clk),
    .dsa_rst        (rst),
    .dsa_cmd_buffer (cmd),
    .empty_cmd      (empty_cmd),
    .rd_en_cmd      (rd_en_cmd),
    .dsa_rsp_buffer (rsp_buf),
    .wr_en_rsp      (wr_en_rsp),
    .full_rsp       (full_rsp),
    .acc_req_vld    (req_vld),
    .acc_req_rdy    (req_rdy),
    .acc_req_opc    (req_opc),
    .acc_req_tag    (req_tag),
    .acc_req_arg0   (req_arg0),
    .acc_req_arg1   (req_arg1),
    .acc_rsp_vld    (rsp_vld),
    .acc_rsp_rdy    (rsp_rdy),
    .acc_rsp_tag    (rsp_tag),
    .acc_rsp_data   (rsp_data),
    .busy           (busy),
    .stat_cmd_cnt   (cmd_cnt),
    .stat_tmo_cnt   (tmo_cnt),
    .stat_drop_cnt  (drop_cnt)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en_rsp) begin
      n_push <= n_push + 1;
      push_data.push_back(rsp_buf);
      push_cyc.push_back(cyc);
    end
    if (req_vld) n_vld <= n_vld + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] mk_cmd(input logic [7:0] opc, input logic [7:0] tag,
                                         input logic [31:0] a0, input logic [31:0] a1);
    return {a1, a0, 16'h0000, tag, opc};
  endfunction

  task automatic issue_to_wait(input logic [7:0] opc, input logic [7:0] tag);
    cmd = mk_cmd(opc, tag, 32'h0, 32'h0);
    empty_cmd = 1'b0;
    tick();
    empty_cmd = 1'b1;
    req_rdy = 1'b1;
    tick();
    req_rdy = 1'b0;
  endtask

  int n0, v0, n, idx;
  logic popped;
  logic [7:0] b2b_tag[3];

  initial begin
    rst = 1'b1; cmd = '0; empty_cmd = 1'b1; full_rsp = 1'b0;
    req_rdy = 1'b0; rsp_vld = 1'b0; rsp_tag = '0; rsp_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_strobes", {rd_en_cmd, wr_en_rsp, req_vld}, 0);
    check("rst_rsp_buf", rsp_buf, 0);
    check("rst_counters", {cmd_cnt, tmo_cnt, drop_cnt}, 0);
    check("rst_rsp_rdy", rsp_rdy, 1);

    // NOP
    v0 = n_vld;
    cmd = mk_cmd(8'h00, 8'h05, 32'h0, 32'h0);
    empty_cmd = 1'b0;
    #1;
    check("nop_rd_en", rd_en_cmd, 1);
    tick();
    empty_cmd = 1'b1;
    #1;
    check("nop_rd_en_one_cycle", rd_en_cmd, 0);
    check("nop_wr_en", wr_en_rsp, 1);
    check("nop_rsp", rsp_buf, 32'h0000_0005);
    check("nop_rsp_rdy_low", rsp_rdy, 0);
    check("nop_cmd_cnt", cmd_cnt, 1);
    tick();
    check("nop_idle", {busy, wr_en_rsp}, 0);
    check("nop_no_req", n_vld - v0, 0);

    // Normal flow with delayed request ready
    cmd = mk_cmd(8'h01, 8'h3C, 32'h1111_2222, 32'h3333_4444);
    empty_cmd = 1'b0;
    tick();
    empty_cmd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("norm_req_hold", {req_vld, req_opc, req_tag, req_arg0, req_arg1},
            {1'b1, 8'h01, 8'h3C, 32'h1111_2222, 32'h3333_4444});
      tick();
    end
    req_rdy = 1'b1;
    #1;
    check("norm_req_vld", req_vld, 1);
    tick();
    req_rdy = 1'b0;
    #1;
    check("norm_wait_vld_low", req_vld, 0);
    tick();
    rsp_vld = 1'b1; rsp_tag = 8'h3C; rsp_data = 32'hCAFE_F00D;
    #1;
    check("norm_rsp_rdy", rsp_rdy, 1);
    tick();
    rsp_vld = 1'b0;
    #1;
    check("norm_push", {wr_en_rsp, rsp_buf}, {1'b1, 32'hCAFE_F00D});
    check("norm_no_drop", drop_cnt, 0);
    tick();
    check("norm_cmd_cnt", cmd_cnt, 2);

    // Timeout
    issue_to_wait(8'h02, 8'h7A);
    n = 0;
    while (!wr_en_rsp && n < 100) begin
      tick();
      n++;
    end
    check("tmo_wait_cycles", n, 16);
    check("tmo_rsp", rsp_buf, 32'hDEAD_007A);
    check("tmo_cnt", tmo_cnt, 1);
    tick();
    n0 = n_push;
    rsp_vld = 1'b1; rsp_tag = 8'h7A; rsp_data = 32'h5555_5555;
    #1;
    check("late_rsp_rdy", rsp_rdy, 1);
    tick();
    rsp_vld = 1'b0;
    tick();
    check("late_drop_cnt", drop_cnt, 1);
    check("late_no_push", n_push - n0, 0);
    check("late_idle", busy, 0);

    // Tag mismatch then backpressure
    issue_to_wait(8'h03, 8'h11);
    rsp_vld = 1'b1; rsp_tag = 8'h10; rsp_data = 32'h0000_0BAD;
    tick();
    rsp_vld = 1'b0;
    #1;
    check("mis_drop_cnt", drop_cnt, 2);
    check("mis_still_wait", {busy, wr_en_rsp, rsp_rdy}, {1'b1, 1'b0, 1'b1});
    full_rsp = 1'b1;
    rsp_vld = 1'b1; rsp_tag = 8'h11; rsp_data = 32'h1234_5678;
    tick();
    rsp_vld = 1'b0;
    n0 = n_push;
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {wr_en_rsp, rsp_buf}, {1'b0, 32'h1234_5678});
      tick();
    end
    full_rsp = 1'b0;
    #1;
    check("bp_release", wr_en_rsp, 1);
    tick();
    check("bp_single_push", n_push - n0, 1);
    check("bp_idle", {busy, wr_en_rsp}, 0);
    check("bp_tmo_unchanged", tmo_cnt, 1);

    // Reset mid-WAIT
    issue_to_wait(8'h04, 8'h22);
    tick();
    n0 = n_push;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_state", {busy, req_vld, wr_en_rsp}, 0);
    check("mrst_counters", {cmd_cnt, tmo_cnt, drop_cnt}, 0);
    check("mrst_rsp_buf", rsp_buf, 0);
    cmd = mk_cmd(8'h00, 8'h33, 32'h0, 32'h0);
    empty_cmd = 1'b0;
    tick();
    empty_cmd = 1'b1;
    #1;
    check("mrst_next_rsp", {wr_en_rsp, rsp_buf}, {1'b1, 32'h0000_0033});
    tick();
    check("mrst_one_push", n_push - n0, 1);
    check("mrst_cmd_cnt", cmd_cnt, 1);

    // Back-to-back NOPs
    b2b_tag[0] = 8'h41; b2b_tag[1] = 8'h42; b2b_tag[2] = 8'h43;
    push_data.delete();
    push_cyc.delete();
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      empty_cmd = (idx >= 3);
      cmd = mk_cmd(8'h00, (idx < 3) ? b2b_tag[idx] : 8'h00, 32'h0, 32'h0);
      #1;
      popped = rd_en_cmd;
      tick();
      if (popped) idx++;
    end
    empty_cmd = 1'b1;
    check("b2b_push_count", push_data.size(), 3);
    if (push_data.size() == 3) begin
      for (int i = 0; i < 3; i++) check("b2b_tag", push_data[i], {24'h0, b2b_tag[i]});
      check("b2b_cadence0", push_cyc[1] - push_cyc[0], 2);
      check("b2b_cadence1", push_cyc[2] - push_cyc[1], 2);
    end
    check("b2b_cmd_cnt", cmd_cnt, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
